// File: rtl/muldiv_seq_if.sv
// Request/response bundle for the iterative multiply/divide sequencer.
// master: issues start/op/x/y/flush and observes busy/done/result.
// slave:  the sequencer itself.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] x;
  logic [XLEN-1:0] y;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, x, y, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, x, y, flush,
    output busy, done, result
  );

endinterface

// File: rtl/muldiv_seq.sv
// Iterative M-extension unit: MUL / MULHU via shift-add, DIVU / REMU via
// restoring division, one bit per cycle for XLEN cycles, sharing one datapath.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - muldiv_seq_if.slave: start/op/x/y/flush in, busy/done/result out
module muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN + 1);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] opb_q;   // multiplicand (mul) or divisor (div)
  logic [XLEN:0]   acc_q;   // product high half (mul) or partial remainder (div)
  logic [XLEN-1:0] lo_q;    // multiplier/product low half (mul) or dividend/quotient (div)
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN+1:0] div_trial;
  logic            div_borrow;
  logic [XLEN:0]   acc_nxt;
  logic [XLEN-1:0] lo_nxt;
  logic [XLEN-1:0] res_nxt;

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

  // One iteration of the shared datapath; result is picked from the post-step values
  // so the final iteration and the result write happen on the same edge.
  always_comb begin
    acc_nxt = acc_q;
    lo_nxt  = lo_q;
    res_nxt = result_q;

    // acc_q[XLEN] is always 0 in multiply mode, so the full width add is exact.
    mul_sum    = acc_q + (lo_q[0] ? {1'b0, opb_q} : (XLEN+1)'(0));
    div_shift  = {acc_q[XLEN-1:0], lo_q[XLEN-1]};
    div_trial  = {1'b0, div_shift} - {2'b00, opb_q};
    div_borrow = div_trial[XLEN+1];

    if (op_q[1]) begin
      // Divisor 0 never borrows: quotient fills with ones, remainder collects the dividend.
      acc_nxt = div_borrow ? div_shift : div_trial[XLEN:0];
      lo_nxt  = {lo_q[XLEN-2:0], ~div_borrow};
    end else begin
      acc_nxt = {1'b0, mul_sum[XLEN:1]};
      lo_nxt  = {mul_sum[0], lo_q[XLEN-1:1]};
    end

    case (op_q)
      OP_MUL, OP_DIVU:   res_nxt = lo_nxt;
      OP_MULHU, OP_REMU: res_nxt = acc_nxt[XLEN-1:0];
      default:           res_nxt = lo_nxt;
    endcase
  end

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= 2'b00;
      opb_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.op;
            // Divide keeps the dividend in lo_q; multiply keeps the multiplier there.
            lo_q   <= bus.op[1] ? bus.x : bus.y;
            opb_q  <= bus.op[1] ? bus.y : bus.x;
            acc_q  <= '0;
            cnt_q  <= CW'(XLEN);
            busy_q <= 1'b1;
            state  <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (bus.flush) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc_q <= acc_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= res_nxt;
              state    <= S_DONE;
            end
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results computed with
// plain arithmetic; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_seq;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_model(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      OP_MUL:   return p[31:0];
      OP_MULHU: return p[63:32];
      OP_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default:  return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expectation in value and timing.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("latency", 32'(cyc), 32'(e.cyc));
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_done: got no done by cycle %0d expected at %0d", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Drive a start at the current negedge; the accepting edge is the next posedge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit expect_done);
    exp_t e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.x     = a;
    bus.y     = b;
    if (expect_done) begin
      e.res = ref_model(op, a, b);
      e.cyc = cyc + 1 + XLEN;
      sb.push_back(e);
      last_res = e.res;
    end
  endtask

  // Full operation; returns at the negedge of the DONE cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_op(op, a, b, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_rise", 32'(bus.busy), 32'd1);
    repeat (XLEN - 1) @(negedge clk);
    check("busy_last_run", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish by 500000");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.x     = '0;
    bus.y     = '0;
    bus.flush = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations with an idle cycle between them.
    run_op(OP_MUL,   32'd7,          32'd6);          @(negedge clk);
    run_op(OP_MULHU, 32'hFFFF_FFFF,  32'hFFFF_FFFF);  @(negedge clk);
    run_op(OP_DIVU,  32'd100,        32'd7);          @(negedge clk);
    run_op(OP_REMU,  32'd100,        32'd7);          @(negedge clk);
    run_op(OP_DIVU,  32'h8000_0000,  32'd1);          @(negedge clk);
    run_op(OP_DIVU,  32'd5,          32'd0);          @(negedge clk);
    run_op(OP_REMU,  32'd5,          32'd0);          @(negedge clk);

    // Back-to-back: second start lands in the DONE cycle of the first.
    run_op(OP_MUL,  32'd3, 32'd4);
    run_op(OP_DIVU, 32'd9, 32'd2);
    @(negedge clk);

    // Flush during RUN cycle 10: no done, result keeps the previous value.
    start_op(OP_DIVU, 32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", 32'(bus.busy), 32'd0);
    repeat (XLEN + 3) @(negedge clk);
    check("flush_result_held", bus.result, last_res);

    // Start during RUN cycle 5 with new operands is ignored.
    start_op(OP_MUL, 32'd11, 32'd13, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.x     = 32'd999;
    bus.y     = 32'd0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (XLEN - 5) @(negedge clk);
    check("ignored_start_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);

    // Asynchronous reset at RUN cycle 17, then a normal operation.
    start_op(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_result", bus.result, 32'd0);
    sb.delete();
    last_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(OP_REMU, 32'd12345, 32'd100);
    @(negedge clk);

    // Randomized operations with random gaps (gap 0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      rop = 2'($urandom_range(0, 3));
      ra  = rnd_operand();
      rb  = rnd_operand();
      run_op(rop, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (XLEN + 5) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
